// File: rtl/mac_filter_stream.sv
// mac_filter_stream
//   Avalon-ST destination-MAC packet filter. Buffers the header beats of each
//   packet, looks the 48-bit destination MAC up in a NUM_ADDR-entry table and
//   either forwards the whole packet unchanged or drops it. Saturating pass,
//   drop and runt counters.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_data/valid/sop/eop/empty   receive stream (first byte in MSBs)
//   in_ready                      receive backpressure
//   out_data/valid/sop/eop/empty  transmit stream
//   out_ready                     transmit backpressure
//   cfg_wr/idx/mac/en             table entry write port
//   cnt_clr                       synchronous clear of all counters
//   pass_cnt/drop_cnt/runt_cnt    statistics
//
// Build option
//   MAC_FILTER_BCAST_EN : when defined, FF:FF:FF:FF:FF:FF always matches.
module mac_filter_stream #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ADDR    = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    input  logic                   out_ready,
    input  logic                   cfg_wr,
    input  logic [((NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1)-1:0] cfg_idx,
    input  logic [47:0]            cfg_mac,
    input  logic                   cfg_en,
    input  logic                   cnt_clr,
    output logic [COUNT_WIDTH-1:0] pass_cnt,
    output logic [COUNT_WIDTH-1:0] drop_cnt,
    output logic [COUNT_WIDTH-1:0] runt_cnt
);

    localparam int IDX_W     = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam int HDR_BEATS = (48 + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PTR_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(HDR_BEATS - 1);

    typedef enum logic [2:0] {IDLE, HDR, DECIDE, REPLAY, FWD, DROP} state_t;

    state_t                 state;
    logic                   run;        // low during and one cycle after reset
    logic [DATA_WIDTH-1:0]  buf_data  [HDR_BEATS];
    logic                   buf_eop   [HDR_BEATS];
    logic [EMPTY_WIDTH-1:0] buf_empty [HDR_BEATS];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic [47:0]            tbl_mac [NUM_ADDR];
    logic [NUM_ADDR-1:0]    tbl_en;

    logic [HDR_BEATS*DATA_WIDTH-1:0] hdr_flat;
    logic [47:0]            dest;
    logic                   match;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   rd_last;
    logic                   wr_last;
    logic                   pass_inc;
    logic                   drop_inc;
    logic [1:0]             runt_inc;

    // Header beats concatenated with slot 0 in the MSBs; the MAC is the top 48 bits.
    always_comb begin
        hdr_flat = '0;
        for (int unsigned i = 0; i < HDR_BEATS; i++) begin
            hdr_flat[(HDR_BEATS - 1 - i) * DATA_WIDTH +: DATA_WIDTH] = buf_data[i];
        end
        dest = hdr_flat[HDR_BEATS * DATA_WIDTH - 1 -: 48];
    end

    always_comb begin
        match = 1'b0;
        for (int unsigned i = 0; i < NUM_ADDR; i++) begin
            if (tbl_en[i] && (tbl_mac[i] == dest)) match = 1'b1;
        end
`ifdef MAC_FILTER_BCAST_EN
        if (dest == '1) match = 1'b1;
`endif
    end

    // Stream outputs: replayed header beats come from the buffer, body beats
    // in FWD pass straight through.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_empty = '0;
        case (state)
            IDLE, HDR, DROP: in_ready = run;
            REPLAY: begin
                out_valid = 1'b1;
                out_data  = buf_data[rd_ptr];
                out_sop   = (rd_ptr == '0);
                out_eop   = buf_eop[rd_ptr];
                out_empty = buf_empty[rd_ptr];
            end
            FWD: begin
                in_ready  = out_ready;
                out_valid = in_valid;
                out_data  = in_data;
                out_sop   = in_sop;
                out_eop   = in_eop;
                out_empty = in_empty;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        rd_last  = (rd_ptr == LAST_SLOT);
        wr_last  = (wr_ptr == LAST_SLOT);
        pass_inc = ((state == REPLAY) && out_xfer && rd_last && buf_eop[rd_ptr]) ||
                   ((state == FWD) && in_xfer && in_eop);
        drop_inc = (state == DECIDE) && !match;
        runt_inc = 2'd0;
        if ((state == IDLE) && in_xfer && in_sop && in_eop && (HDR_BEATS > 1)) begin
            runt_inc = 2'd1;
        end else if ((state == HDR) && in_xfer) begin
            // A sop mid-header aborts the old packet; if it also carries eop
            // the new packet is a runt too.
            if (in_sop) runt_inc = 2'd1 + {1'b0, in_eop};
            else if (in_eop && !wr_last) runt_inc = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            run    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < HDR_BEATS; i++) begin
                buf_data[i]  <= '0;
                buf_eop[i]   <= 1'b0;
                buf_empty[i] <= '0;
            end
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_xfer && in_sop) begin
                        buf_data[0]  <= in_data;
                        buf_eop[0]   <= in_eop;
                        buf_empty[0] <= in_empty;
                        wr_ptr       <= PTR_W'(1);
                        if (HDR_BEATS == 1) state <= DECIDE;
                        else if (!in_eop)   state <= HDR;
                    end
                end
                HDR: begin
                    if (in_xfer) begin
                        if (in_sop) begin
                            buf_data[0]  <= in_data;
                            buf_eop[0]   <= in_eop;
                            buf_empty[0] <= in_empty;
                            wr_ptr       <= PTR_W'(1);
                            if (in_eop) state <= IDLE;
                        end else begin
                            buf_data[wr_ptr]  <= in_data;
                            buf_eop[wr_ptr]   <= in_eop;
                            buf_empty[wr_ptr] <= in_empty;
                            wr_ptr            <= wr_ptr + 1'b1;
                            if (wr_last)     state <= DECIDE;
                            else if (in_eop) state <= IDLE;
                        end
                    end
                end
                DECIDE: begin
                    rd_ptr <= '0;
                    if (match)                   state <= REPLAY;
                    else if (buf_eop[LAST_SLOT]) state <= IDLE;
                    else                         state <= DROP;
                end
                REPLAY: begin
                    if (out_ready) begin
                        if (rd_last) state <= buf_eop[rd_ptr] ? IDLE : FWD;
                        else         rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                FWD, DROP: begin
                    if (in_xfer && in_eop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only an in-range index matches a slot, so out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_en <= '0;
            for (int unsigned i = 0; i < NUM_ADDR; i++) tbl_mac[i] <= '0;
        end else if (cfg_wr) begin
            for (int unsigned i = 0; i < NUM_ADDR; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    tbl_mac[i] <= cfg_mac;
                    tbl_en[i]  <= cfg_en;
                end
            end
        end
    end

    function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] c,
                                                       input logic [1:0] inc);
        logic [COUNT_WIDTH:0] s;
        s = {1'b0, c} + {{(COUNT_WIDTH - 1){1'b0}}, inc};
        return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
            runt_cnt <= '0;
        end else if (cnt_clr) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
            runt_cnt <= '0;
        end else begin
            pass_cnt <= sat_add(pass_cnt, {1'b0, pass_inc});
            drop_cnt <= sat_add(drop_cnt, {1'b0, drop_inc});
            runt_cnt <= sat_add(runt_cnt, runt_inc);
        end
    end

endmodule

// File: tb/tb_mac_filter_stream.sv
// Scoreboard bench for mac_filter_stream at DATA_WIDTH=32 (2 header beats),
// NUM_ADDR=4 and 4-bit counters so saturation is reachable.
module tb_mac_filter_stream;

    localparam int DW = 32;
    localparam int EW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [EW-1:0] in_empty = '0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic          out_ready = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [47:0]   cfg_mac = '0;
    logic          cfg_en = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] runt_cnt;

    mac_filter_stream #(.DATA_WIDTH(DW), .NUM_ADDR(4), .COUNT_WIDTH(CW), .EMPTY_WIDTH(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_ready(out_ready),
        .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_mac(cfg_mac), .cfg_en(cfg_en),
        .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
        logic [EW-1:0] m;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    first_out_cyc = -1;
    int    tog_mode = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = (tog_mode != 0) ? !out_ready : 1'b1;
    end

    // Monitor: pops the scoreboard on every output transfer and checks that
    // a stalled beat is still presented unchanged one cycle later.
    logic  prev_stall = 1'b0;
    beat_t prev_b;
    always @(negedge clk) begin
        beat_t cur;
        beat_t want;
        cur = {out_data, out_sop, out_eop, out_empty};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || cur !== prev_b) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b beat=%h need valid=1 beat=%h",
                             out_valid, cur, prev_b);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got d=%h sop=%b eop=%b need no output",
                             out_data, out_sop, out_eop);
                end else begin
                    want = exp_q.pop_front();
                    if (cur !== want) begin
                        errors++;
                        $display("FAIL out_beat got d=%h sop=%b eop=%b emp=%0d need d=%h sop=%b eop=%b emp=%0d",
                                 out_data, out_sop, out_eop, out_empty, want.d, want.s, want.e, want.m);
                    end
                end
                if (out_sop && first_out_cyc < 0) first_out_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_b     = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s, input logic e,
                        input logic [EW-1:0] m, input logic expect_out);
        logic acc;
        if (expect_out) exp_q.push_back({d, s, e, m});
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = m;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 need beat %h accepted", d);
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick(1);
        chk(name, exp_q.size(), 0);
        tick(2);
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [47:0] mac, input logic en);
        cfg_idx = idx;
        cfg_mac = mac;
        cfg_en  = en;
        cfg_wr  = 1'b1;
        tick(1);
        cfg_wr  = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
    endtask

    task automatic counters(input string name, input int p, input int d, input int r);
        chk({name, "_pass"}, pass_cnt, p);
        chk({name, "_drop"}, drop_cnt, d);
        chk({name, "_runt"}, runt_cnt, r);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got no finish need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sop_cyc;

        // Reset state
        tick(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sop_eop", {out_sop, out_eop}, 0);
        counters("rst", 0, 0, 0);
        rst_n = 1'b1;
        tick(2);

        // Matching 4-beat packet, latency 3
        cfg(2'd0, 48'h0011_2233_4455, 1'b1);
        clr();
        first_out_cyc = -1;
        sop_cyc = cyc;
        send(32'h0011_2233, 1, 0, 0, 1);
        send(32'h4455_0800, 0, 0, 0, 1);
        send(32'hDEAD_BEEF, 0, 0, 0, 1);
        send(32'hCAFE_F00D, 0, 1, 0, 1);
        drain("t1_drain");
        chk("t1_latency", first_out_cyc - sop_cyc, 3);
        counters("t1", 1, 0, 0);

        // Miss: dropped, all beats consumed
        clr();
        send(32'h0011_2233, 1, 0, 0, 0);
        send(32'h4466_0800, 0, 0, 0, 0);
        send(32'hDEAD_BEEF, 0, 0, 0, 0);
        send(32'hCAFE_F00D, 0, 1, 0, 0);
        drain("t2_drain");
        counters("t2", 0, 1, 0);

        // 1-beat runt, then a matching packet right behind it
        clr();
        send(32'h1234_5678, 1, 1, 0, 0);
        first_out_cyc = -1;
        sop_cyc = cyc;
        send(32'h0011_2233, 1, 0, 0, 1);
        send(32'h4455_0001, 0, 0, 0, 1);
        send(32'h7777_7777, 0, 1, 3, 1);
        drain("t3_drain");
        chk("t3_latency", first_out_cyc - sop_cyc, 3);
        counters("t3", 1, 0, 1);

        // sop inside the header restarts capture; aborted packet is a runt
        clr();
        send(32'hAAAA_AAAA, 1, 0, 0, 0);
        send(32'h0011_2233, 1, 0, 0, 1);
        send(32'h4455_0800, 0, 0, 0, 1);
        send(32'h1111_1111, 0, 1, 0, 1);
        drain("t4_drain");
        counters("t4", 1, 0, 1);

        // 6-beat packet with out_ready toggling
        clr();
        tog_mode = 1;
        send(32'h0011_2233, 1, 0, 0, 1);
        send(32'h4455_0102, 0, 0, 0, 1);
        send(32'h0304_0506, 0, 0, 0, 1);
        send(32'h0708_090A, 0, 0, 0, 1);
        send(32'h0B0C_0D0E, 0, 0, 0, 1);
        send(32'h0F10_0000, 0, 1, 2, 1);
        drain("t5_drain");
        tog_mode = 0;
        tick(2);
        counters("t5", 1, 0, 0);

        // Table entry 3; header-only packets (eop on last header beat)
        cfg(2'd3, 48'hA1B2_C3D4_E5F6, 1'b1);
        clr();
        send(32'hA1B2_C3D4, 1, 0, 0, 1);
        send(32'hE5F6_0000, 0, 0, 0, 1);
        send(32'h5555_5555, 0, 1, 1, 1);
        send(32'h0011_2233, 1, 0, 0, 1);
        send(32'h4455_FFFF, 0, 1, 1, 1);
        send(32'h0011_2233, 1, 0, 0, 0);
        send(32'h4466_FFFF, 0, 1, 0, 0);
        send(32'hA1B2_C3D4, 1, 0, 0, 1);
        send(32'hE5F6_9999, 0, 1, 0, 1);
        drain("t6_drain");
        counters("t6", 3, 1, 0);

        // Broadcast with every entry disabled
        cfg(2'd0, 48'h0011_2233_4455, 1'b0);
        cfg(2'd3, 48'hA1B2_C3D4_E5F6, 1'b0);
        clr();
`ifdef MAC_FILTER_BCAST_EN
        send(32'hFFFF_FFFF, 1, 0, 0, 1);
        send(32'hFFFF_0102, 0, 0, 0, 1);
        send(32'h0304_0506, 0, 1, 1, 1);
        drain("t7_drain");
        counters("t7", 1, 0, 0);
`else
        send(32'hFFFF_FFFF, 1, 0, 0, 0);
        send(32'hFFFF_0102, 0, 0, 0, 0);
        send(32'h0304_0506, 0, 1, 1, 0);
        drain("t7_drain");
        counters("t7", 0, 1, 0);
`endif

        // Runt counter saturates; cnt_clr beats a same-cycle increment
        clr();
        for (int k = 0; k < 17; k++) send(32'h0000_0000 + k, 1, 1, 0, 0);
        tick(1);
        chk("sat_runt", runt_cnt, 15);
        cnt_clr = 1'b1;
        send(32'h5A5A_5A5A, 1, 1, 0, 0);
        cnt_clr = 1'b0;
        tick(1);
        chk("clr_priority_runt", runt_cnt, 0);

        // Reset in FWD clears counters and table
        cfg(2'd0, 48'h0011_2233_4455, 1'b1);
        send(32'h9999_9999, 1, 1, 0, 0);
        send(32'h0011_2233, 1, 0, 0, 1);
        send(32'h4455_0800, 0, 0, 0, 1);
        send(32'h2222_2222, 0, 0, 0, 1);
        chk("t8_pre_runt", runt_cnt, 1);
        rst_n = 1'b0;
        #2;
        chk("t8_rst_out_valid", out_valid, 0);
        chk("t8_rst_in_ready", in_ready, 0);
        chk("t8_rst_out_data", out_data, 0);
        counters("t8_rst", 0, 0, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send(32'h0011_2233, 1, 0, 0, 0);
        send(32'h4455_0800, 0, 0, 0, 0);
        send(32'h3333_3333, 0, 0, 0, 0);
        send(32'h4444_4444, 0, 1, 0, 0);
        drain("t8_drain");
        counters("t8", 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
